// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner tags and the memory request bundle.
package dmem_arb_pkg;

   localparam logic [1:0] CPU_PRI  = 2'd0;
   localparam logic [1:0] DMA_PRI  = 2'd1;
   localparam logic [1:0] DMA_LOCK = 2'd2;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Priority FSM for dmem_arbiter: CPU default priority, DMA anti-starvation and bounded lock bursts.
// DMA_LOCK and lock_cnt exist only when DMEM_ARB_LOCK_EN is defined.
module dmem_arb_fsm
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 4,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic dma_lock,
   output logic gnt_cpu,
   output logic gnt_dma
);

   logic [1:0] state_q, state_d;
   logic [3:0] wait_q, wait_d;
`ifdef DMEM_ARB_LOCK_EN
   logic [7:0] lock_q, lock_d;
`else
   logic       unused_lock;
   assign unused_lock = dma_lock;
`endif

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      gnt_cpu = 1'b0;
      gnt_dma = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         DMA_PRI: begin
            state_d = CPU_PRI;
            wait_d  = '0;
            if (dma_req) begin
               gnt_dma = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
               if (dma_lock) begin
                  state_d = DMA_LOCK;
                  lock_d  = 8'd1;
               end
`endif
            end else begin
               gnt_cpu = cpu_req;
            end
         end
`ifdef DMEM_ARB_LOCK_EN
         DMA_LOCK: begin
            if ((lock_q == 8'(LOCK_MAX)) && cpu_req) begin
               // Lock budget spent: hand the CPU this cycle and drop the lock
               gnt_cpu = 1'b1;
               state_d = CPU_PRI;
               lock_d  = '0;
            end else if (dma_req) begin
               gnt_dma = 1'b1;
               wait_d  = '0;
               if (lock_q != 8'hff) lock_d = lock_q + 8'd1;
               if (!dma_lock) begin
                  state_d = CPU_PRI;
                  lock_d  = '0;
               end
            end else begin
               gnt_cpu = cpu_req;
               state_d = CPU_PRI;
               lock_d  = '0;
            end
         end
`endif
         default: begin
            if (cpu_req) begin
               gnt_cpu = 1'b1;
               if (dma_req) begin
                  wait_d = wait_q + 4'd1;
                  if (wait_q == 4'(WAIT_MAX - 1)) state_d = DMA_PRI;
               end
            end else if (dma_req) begin
               gnt_dma = 1'b1;
               wait_d  = '0;
`ifdef DMEM_ARB_LOCK_EN
               if (dma_lock) begin
                  state_d = DMA_LOCK;
                  lock_d  = 8'd1;
               end
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CPU_PRI;
         wait_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
         lock_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
`ifdef DMEM_ARB_LOCK_EN
         lock_q  <= lock_d;
`endif
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory (CPU vs DMA/loader).
// Optional DMA lock bursts are enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 4,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_cpu_req,
   input  logic        I_cpu_we,
   input  logic [31:0] I_cpu_addr,
   input  logic [31:0] I_cpu_wdata,
   output logic        O_cpu_gnt,
   output logic        O_cpu_stall,
   output logic        O_cpu_rvalid,
   output logic [31:0] O_cpu_rdata,
   input  logic        I_dma_req,
   input  logic        I_dma_we,
   input  logic [31:0] I_dma_addr,
   input  logic [31:0] I_dma_wdata,
   input  logic        I_dma_lock,
   output logic        O_dma_gnt,
   output logic        O_dma_rvalid,
   output logic [31:0] O_dma_rdata,
   output logic        O_mem_we,
   output logic [31:0] O_mem_addr,
   output logic [31:0] O_mem_wdata,
   input  logic [31:0] I_mem_rdata
);

   logic     gnt_cpu, gnt_dma;
   logic     owner_q, rd_q;
   mem_req_t cpu_port, dma_port, mem_port;

   dmem_arb_fsm #(
      .WAIT_MAX(WAIT_MAX),
      .LOCK_MAX(LOCK_MAX)
   ) u_fsm (
      .clk     (I_clk),
      .rst_n   (I_rst_n),
      .cpu_req (I_cpu_req),
      .dma_req (I_dma_req),
      .dma_lock(I_dma_lock),
      .gnt_cpu (gnt_cpu),
      .gnt_dma (gnt_dma)
   );

   assign cpu_port = {I_cpu_we, I_cpu_addr, I_cpu_wdata};
   assign dma_port = {I_dma_we, I_dma_addr, I_dma_wdata};

   // Idle memory sees the CPU address with writes suppressed
   always_comb begin
      mem_port    = gnt_dma ? dma_port : cpu_port;
      mem_port.we = mem_port.we & (gnt_cpu | gnt_dma);
   end

   assign O_mem_we    = mem_port.we;
   assign O_mem_addr  = mem_port.addr;
   assign O_mem_wdata = mem_port.wdata;

   assign O_cpu_gnt   = gnt_cpu;
   assign O_dma_gnt   = gnt_dma;
   assign O_cpu_stall = I_cpu_req & ~gnt_cpu;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         owner_q <= OWN_CPU;
         rd_q    <= 1'b0;
      end else begin
         owner_q <= gnt_dma ? OWN_DMA : OWN_CPU;
         rd_q    <= (gnt_cpu & ~I_cpu_we) | (gnt_dma & ~I_dma_we);
      end
   end

   assign O_cpu_rvalid = rd_q & (owner_q == OWN_CPU);
   assign O_dma_rvalid = rd_q & (owner_q == OWN_DMA);
   assign O_cpu_rdata  = O_cpu_rvalid ? I_mem_rdata : 32'h0;
   assign O_dma_rdata  = O_dma_rvalid ? I_mem_rdata : 32'h0;

endmodule
